// File: rtl/mci_boot_seq.sv
// mci_boot_seq: ordered multi-stage boot sequencer with a per-stage req/done
// handshake, per-stage bypass, a watchdog timeout, MCU reset release at a
// chosen stage, and hitless MCU reset pulses after boot completes.
module mci_boot_seq #(
  parameter int NUM_STAGES     = 8,
  parameter int STG_W          = $clog2(NUM_STAGES),
  parameter int MCU_STAGE      = 4,
  parameter int MCU_RST_CYCLES = 10,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  boot_start,
  input  logic [NUM_STAGES-1:0] stage_bypass,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_STAGES-1:0] stage_req,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  mcu_update_req,
  output logic                  mcu_rst_b,
  output logic [2:0]            boot_state,
  output logic [STG_W-1:0]      cur_stage,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic [STG_W-1:0]      err_stage,
  output logic [7:0]            update_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_RST_MCU = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // Down-counter width large enough to hold MCU_RST_CYCLES-1 (at least 1 bit).
  localparam int RC_W = $clog2(MCU_RST_CYCLES + 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
  localparam logic [STG_W-1:0] MCU_STG    = STG_W'(MCU_STAGE);
  localparam logic [RC_W-1:0]  RC_LOAD    = RC_W'(MCU_RST_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [STG_W-1:0]        cur_stage_q, cur_stage_d;
  logic [STG_W-1:0]        err_stage_q, err_stage_d;
  logic                    mcu_rst_b_q, mcu_rst_b_d;
  logic [7:0]              update_count_q, update_count_d;
  logic [TIMEOUT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [TIMEOUT_W-1:0]    limit_q, limit_d;
  logic [NUM_STAGES-1:0]   bypass_q, bypass_d;
  logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;

  logic                    stg_bypassed;
  logic                    stg_done;
  logic [NUM_STAGES-1:0]   req_onehot;

  // Decode of the current stage from registered state only.
  always_comb begin
    stg_bypassed = bypass_q[cur_stage_q];
    stg_done     = stage_done[cur_stage_q];
    req_onehot   = NUM_STAGES'(1) << cur_stage_q;
  end

  // Next-state and datapath update for the boot FSM.
  always_comb begin
    state_d        = state_q;
    cur_stage_d    = cur_stage_q;
    err_stage_d    = err_stage_q;
    mcu_rst_b_d    = mcu_rst_b_q;
    update_count_d = update_count_q;
    tmo_cnt_d      = tmo_cnt_q;
    limit_d        = limit_q;
    bypass_d       = bypass_q;
    rst_cnt_d      = rst_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (boot_start) begin
          state_d     = ST_RUN;
          cur_stage_d = '0;
          tmo_cnt_d   = '0;
          bypass_d    = stage_bypass;
          limit_d     = timeout_limit;
        end
      end

      ST_RUN: begin
        // A bypassed stage always advances after one cycle; otherwise done
        // takes priority over a timeout landing in the same cycle.
        if (stg_bypassed || stg_done) begin
          tmo_cnt_d = '0;
          if (cur_stage_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            cur_stage_d = cur_stage_q + STG_W'(1);
          end
        end else if (limit_q != '0) begin
          if (tmo_cnt_q == limit_q - TIMEOUT_W'(1)) begin
            state_d     = ST_ERROR;
            err_stage_d = cur_stage_q;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (mcu_update_req) begin
          state_d     = ST_RST_MCU;
          mcu_rst_b_d = 1'b0;
          rst_cnt_d   = RC_LOAD;
        end
      end

      ST_RST_MCU: begin
        if (rst_cnt_q == '0) begin
          state_d     = ST_DONE;
          mcu_rst_b_d = 1'b1;
          if (update_count_q != 8'hFF) begin
            update_count_d = update_count_q + 8'd1;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end

      ST_ERROR: begin
        // Terminal until reset; everything holds.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // MCU reset is released on the edge that first makes MCU_STAGE current.
    if (state_d == ST_RUN && cur_stage_d == MCU_STG) begin
      mcu_rst_b_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= ST_IDLE;
      cur_stage_q    <= '0;
      err_stage_q    <= '0;
      mcu_rst_b_q    <= 1'b0;
      update_count_q <= '0;
      tmo_cnt_q      <= '0;
      limit_q        <= '0;
      bypass_q       <= '0;
      rst_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cur_stage_q    <= cur_stage_d;
      err_stage_q    <= err_stage_d;
      mcu_rst_b_q    <= mcu_rst_b_d;
      update_count_q <= update_count_d;
      tmo_cnt_q      <= tmo_cnt_d;
      limit_q        <= limit_d;
      bypass_q       <= bypass_d;
      rst_cnt_q      <= rst_cnt_d;
    end
  end

  // Outputs are decoded from registered state.
  always_comb begin
    stage_req    = (state_q == ST_RUN && !stg_bypassed) ? req_onehot : '0;
    mcu_rst_b    = mcu_rst_b_q;
    boot_state   = state_q;
    cur_stage    = cur_stage_q;
    boot_done    = (state_q == ST_DONE) || (state_q == ST_RST_MCU);
    boot_err     = (state_q == ST_ERROR);
    err_stage    = err_stage_q;
    update_count = update_count_q;
  end

endmodule

// File: tb/tb_mci_boot_seq.sv
// Self-checking bench for mci_boot_seq with default parameters.
module tb_mci_boot_seq;

  logic        clk;
  logic        rst_b;
  logic        boot_start;
  logic [7:0]  stage_bypass;
  logic [15:0] timeout_limit;
  logic [7:0]  stage_req;
  logic [7:0]  stage_done;
  logic        mcu_update_req;
  logic        mcu_rst_b;
  logic [2:0]  boot_state;
  logic [2:0]  cur_stage;
  logic        boot_done;
  logic        boot_err;
  logic [2:0]  err_stage;
  logic [7:0]  update_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] req_q[$];
  logic [7:0] cnt_q[$];

  mci_boot_seq #(
    .NUM_STAGES(8), .STG_W(3), .MCU_STAGE(4), .MCU_RST_CYCLES(10), .TIMEOUT_W(16)
  ) dut (
    .clk(clk), .rst_b(rst_b), .boot_start(boot_start), .stage_bypass(stage_bypass),
    .timeout_limit(timeout_limit), .stage_req(stage_req), .stage_done(stage_done),
    .mcu_update_req(mcu_update_req), .mcu_rst_b(mcu_rst_b), .boot_state(boot_state),
    .cur_stage(cur_stage), .boot_done(boot_done), .boot_err(boot_err),
    .err_stage(err_stage), .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_b = 1'b0; boot_start = 1'b0; stage_done = '0; mcu_update_req = 1'b0;
    stage_bypass = '0; timeout_limit = '0;
    tick; tick;
    rst_b = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_b = 1'b0; boot_start = 1'b0; stage_done = '0; mcu_update_req = 1'b0;
    stage_bypass = '0; timeout_limit = '0;
    tick;
    checks++; if (boot_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", boot_state); end
    checks++; if (cur_stage !== 3'd0) begin errors++; $display("FAIL rst_cur_stage: got %0d expected 0", cur_stage); end
    checks++; if (stage_req !== 8'h00) begin errors++; $display("FAIL rst_stage_req: got %0h expected 0", stage_req); end
    checks++; if (mcu_rst_b !== 1'b0) begin errors++; $display("FAIL rst_mcu_rst_b: got %0b expected 0", mcu_rst_b); end
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL rst_boot_done: got %0b expected 0", boot_done); end
    checks++; if (boot_err !== 1'b0) begin errors++; $display("FAIL rst_boot_err: got %0b expected 0", boot_err); end
    checks++; if (err_stage !== 3'd0) begin errors++; $display("FAIL rst_err_stage: got %0d expected 0", err_stage); end
    checks++; if (update_count !== 8'd0) begin errors++; $display("FAIL rst_update_count: got %0d expected 0", update_count); end
    rst_b = 1'b1;
    tick; tick;
    checks++; if (boot_state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", boot_state); end
  endtask

  // Full boot with a responder that returns done dly cycles after each req.
  task automatic run_boot(input string name, input logic [7:0] byp, input int dly);
    int cyc, hi, rise, exp_total, exp_rise;
    logic [7:0] prev, exp_req;
    exp_total = 0; exp_rise = -1;
    for (int s = 0; s < 8; s++) begin
      if (s == 4) exp_rise = exp_total;
      if (!byp[s]) begin
        req_q.push_back(8'(1 << s));
        exp_total += dly + 1;
      end else begin
        exp_total += 1;
      end
    end
    do_reset;
    stage_bypass = byp; timeout_limit = '0; boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    cyc = 0; hi = 0; rise = -1; prev = '0;
    while (boot_state == 3'd1 && cyc < 200) begin
      if (mcu_rst_b === 1'b1 && rise < 0) rise = cyc;
      if (prev != 8'h00 && stage_req != prev) begin
        checks++;
        if (hi != dly + 1) begin errors++; $display("FAIL %s_req_len: got %0d expected %0d", name, hi, dly + 1); end
      end
      if (stage_req != 8'h00) begin
        if (stage_req != prev) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++; $display("FAIL %s_extra_req: got %0h expected none", name, stage_req);
          end else begin
            exp_req = req_q.pop_front();
            if (stage_req !== exp_req) begin errors++; $display("FAIL %s_req_order: got %0h expected %0h", name, stage_req, exp_req); end
          end
          hi = 0;
        end
        hi++;
        stage_done = (hi == dly + 1) ? stage_req : 8'h00;
      end else begin
        stage_done = 8'h00;
      end
      prev = stage_req;
      tick;
      cyc++;
    end
    stage_done = 8'h00;
    if (prev != 8'h00) begin
      checks++;
      if (hi != dly + 1) begin errors++; $display("FAIL %s_last_req_len: got %0d expected %0d", name, hi, dly + 1); end
    end
    checks++; if (cyc != exp_total) begin errors++; $display("FAIL %s_boot_cycles: got %0d expected %0d", name, cyc, exp_total); end
    checks++; if (rise != exp_rise) begin errors++; $display("FAIL %s_mcu_release: got %0d expected %0d", name, rise, exp_rise); end
    checks++; if (req_q.size() != 0) begin errors++; $display("FAIL %s_missing_req: got %0d left expected 0", name, req_q.size()); end
    req_q.delete();
    checks++; if (boot_state !== 3'd2) begin errors++; $display("FAIL %s_done_state: got %0d expected 2", name, boot_state); end
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL %s_boot_done: got %0b expected 1", name, boot_done); end
    checks++; if (mcu_rst_b !== 1'b1) begin errors++; $display("FAIL %s_mcu_rst_b: got %0b expected 1", name, mcu_rst_b); end
  endtask

  task automatic test_timeout;
    int hi;
    logic [7:0] exp_req;
    do_reset;
    req_q.push_back(8'h01); req_q.push_back(8'h02); req_q.push_back(8'h04);
    timeout_limit = 16'd5; boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_req = req_q.pop_front();
      checks++; if (stage_req !== exp_req) begin errors++; $display("FAIL to_req_s%0d: got %0h expected %0h", s, stage_req, exp_req); end
      stage_done = stage_req;
      tick;
      stage_done = 8'h00;
    end
    exp_req = req_q.pop_front();
    checks++; if (stage_req !== exp_req) begin errors++; $display("FAIL to_req_s2: got %0h expected %0h", stage_req, exp_req); end
    hi = 0;
    while (stage_req == 8'h04 && hi < 50) begin hi++; tick; end
    checks++; if (hi != 5) begin errors++; $display("FAIL to_req_len: got %0d expected 5", hi); end
    checks++; if (boot_state !== 3'd4) begin errors++; $display("FAIL to_state: got %0d expected 4", boot_state); end
    checks++; if (boot_err !== 1'b1) begin errors++; $display("FAIL to_boot_err: got %0b expected 1", boot_err); end
    checks++; if (err_stage !== 3'd2) begin errors++; $display("FAIL to_err_stage: got %0d expected 2", err_stage); end
    checks++; if (stage_req !== 8'h00) begin errors++; $display("FAIL to_req_off: got %0h expected 0", stage_req); end
    checks++; if (mcu_rst_b !== 1'b0) begin errors++; $display("FAIL to_mcu_rst_b: got %0b expected 0", mcu_rst_b); end
    stage_done = 8'h04; mcu_update_req = 1'b1; boot_start = 1'b1;
    tick; tick;
    stage_done = 8'h00; mcu_update_req = 1'b0; boot_start = 1'b0;
    checks++; if (boot_state !== 3'd4) begin errors++; $display("FAIL to_terminal: got %0d expected 4", boot_state); end
    checks++; if (cur_stage !== 3'd2) begin errors++; $display("FAIL to_cur_hold: got %0d expected 2", cur_stage); end
  endtask

  task automatic test_done_wins;
    int hi;
    do_reset;
    timeout_limit = 16'd5; boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    stage_done = stage_req;
    tick;
    stage_done = 8'h00;
    tick; tick; tick; tick;
    checks++; if (stage_req !== 8'h02) begin errors++; $display("FAIL dw_req_5th: got %0h expected 2", stage_req); end
    stage_done = 8'h02;
    tick;
    stage_done = 8'h00;
    checks++; if (boot_state !== 3'd1) begin errors++; $display("FAIL dw_state: got %0d expected 1", boot_state); end
    checks++; if (cur_stage !== 3'd2) begin errors++; $display("FAIL dw_cur_stage: got %0d expected 2", cur_stage); end
    checks++; if (boot_err !== 1'b0) begin errors++; $display("FAIL dw_boot_err: got %0b expected 0", boot_err); end
    hi = 0;
    while (stage_req == 8'h04 && hi < 50) begin hi++; tick; end
    checks++; if (hi != 5) begin errors++; $display("FAIL dw_next_len: got %0d expected 5", hi); end
    checks++; if (err_stage !== 3'd2) begin errors++; $display("FAIL dw_err_stage: got %0d expected 2", err_stage); end
  endtask

  task automatic test_update;
    int low, cyc;
    logic [7:0] exp_cnt;
    do_reset;
    stage_bypass = 8'hFF; boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    mcu_update_req = 1'b1;
    tick;
    mcu_update_req = 1'b0;
    cyc = 0;
    while (boot_state != 3'd2 && cyc < 20) begin cyc++; tick; end
    tick;
    checks++; if (boot_state !== 3'd2) begin errors++; $display("FAIL upd_no_queue: got %0d expected 2", boot_state); end
    for (int p = 1; p <= 3; p++) begin
      if (p != 2) cnt_q.push_back(8'(p - (p == 3 ? 1 : 0)));
      if (p == 2) continue;
      mcu_update_req = 1'b1;
      tick;
      mcu_update_req = 1'b0;
      checks++; if (boot_state !== 3'd3 || boot_done !== 1'b1) begin errors++; $display("FAIL upd_enter_%0d: got state %0d done %0b expected 3 1", p, boot_state, boot_done); end
      low = 0;
      while (mcu_rst_b == 1'b0 && low < 50) begin
        low++;
        mcu_update_req = (p == 1 && low == 3);
        tick;
      end
      mcu_update_req = 1'b0;
      checks++; if (low != 10) begin errors++; $display("FAIL upd_low_len_%0d: got %0d expected 10", p, low); end
      checks++; if (boot_state !== 3'd2) begin errors++; $display("FAIL upd_back_done_%0d: got %0d expected 2", p, boot_state); end
      exp_cnt = cnt_q.pop_front();
      checks++; if (update_count !== exp_cnt) begin errors++; $display("FAIL upd_count_%0d: got %0d expected %0d", p, update_count, exp_cnt); end
      tick;
      checks++; if (boot_state !== 3'd2) begin errors++; $display("FAIL upd_stay_done_%0d: got %0d expected 2", p, boot_state); end
    end
    boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    checks++; if (boot_state !== 3'd2) begin errors++; $display("FAIL upd_no_restart: got %0d expected 2", boot_state); end
  endtask

  task automatic test_reset_mid;
    int cyc, hi;
    do_reset;
    boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    cyc = 0;
    while (cur_stage != 3'd5 && cyc < 50) begin stage_done = stage_req; tick; cyc++; end
    stage_done = 8'h00;
    checks++; if (boot_state !== 3'd1 || mcu_rst_b !== 1'b1) begin errors++; $display("FAIL mid_pre: got state %0d mcu %0b expected 1 1", boot_state, mcu_rst_b); end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({boot_state, cur_stage, stage_req, mcu_rst_b, boot_done, boot_err, err_stage, update_count} !== 32'h0) begin
      errors++; $display("FAIL mid_async_rst: got state %0d stage %0d req %0h mcu %0b expected all 0", boot_state, cur_stage, stage_req, mcu_rst_b);
    end
    tick;
    rst_b = 1'b1;
    tick;
    checks++; if (boot_state !== 3'd0) begin errors++; $display("FAIL mid_idle: got %0d expected 0", boot_state); end
    req_q.push_back(8'h02);
    stage_bypass = 8'h01; timeout_limit = 16'd3; boot_start = 1'b1;
    tick;
    boot_start = 1'b0;
    checks++; if (cur_stage !== 3'd0 || stage_req !== 8'h00) begin errors++; $display("FAIL mid_restart: got stage %0d req %0h expected 0 0", cur_stage, stage_req); end
    tick;
    checks++; if (stage_req !== req_q[0]) begin errors++; $display("FAIL mid_new_req: got %0h expected %0h", stage_req, req_q[0]); end
    void'(req_q.pop_front());
    hi = 0;
    while (stage_req == 8'h02 && hi < 50) begin hi++; tick; end
    checks++; if (hi != 3) begin errors++; $display("FAIL mid_new_limit: got %0d expected 3", hi); end
    checks++; if (boot_state !== 3'd4 || err_stage !== 3'd1) begin errors++; $display("FAIL mid_new_err: got state %0d err_stage %0d expected 4 1", boot_state, err_stage); end
  endtask

  initial begin
    rst_b = 1'b0; boot_start = 1'b0; stage_done = '0; mcu_update_req = 1'b0;
    stage_bypass = '0; timeout_limit = '0;
    test_reset;
    run_boot("seq", 8'h00, 3);
    run_boot("bypass", 8'hA5, 3);
    test_timeout;
    test_done_wins;
    test_update;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mci_boot_seq.md
Name: mci_boot_seq

Overview:
- Parametrised MCI boot sequencer. It steps through NUM_STAGES ordered boot stages, using a per-stage req/done handshake, optional per-stage bypass and a programmable watchdog timeout.
- It releases MCU reset at a configurable stage.
- After boot it performs hitless MCU reset pulses of MCU_RST_CYCLES on firmware-update request.
- Generalises the fixed MCI boot FSM (idle, fabric, OTP, LCC, MCU, PLL, Caliptra, wait-update, reset-MCU) to any stage count, with error reporting.

Parameters:
- NUM_STAGES, 8, number of ordered boot stages (2..16).
- STG_W, $clog2(NUM_STAGES), width of stage index.
- MCU_STAGE, 4, index of the stage at which mcu_rst_b is released.
- MCU_RST_CYCLES, 10, MCU reset assertion length for hitless update (>=1).
- TIMEOUT_W, 16, width of timeout limit/counter.

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- boot_start  input  1  level; leaves IDLE when sampled high
- stage_bypass  input  NUM_STAGES  per-stage skip mask, captured on IDLE->RUN
- timeout_limit  input  TIMEOUT_W  per-stage cycle limit, 0 = watchdog disabled; captured on IDLE->RUN
- stage_req  output  NUM_STAGES  one-hot request to current stage
- stage_done  input  NUM_STAGES  per-stage completion
- mcu_update_req  input  1  pulse requesting hitless MCU reset
- mcu_rst_b  output  1  MCU reset, active-low
- boot_state  output  3  IDLE=0, RUN=1, DONE=2, RST_MCU=3, ERROR=4
- cur_stage  output  STG_W  current stage index
- boot_done  output  1  high in DONE and RST_MCU
- boot_err  output  1  high in ERROR
- err_stage  output  STG_W  stage that timed out
- update_count  output  8  completed hitless updates, saturating

Behaviour:
Reset values:
- state=IDLE, cur_stage=0, stage_req=0, mcu_rst_b=0, boot_done=0, boot_err=0, err_stage=0, update_count=0.
- Timeout counter=0. Captured bypass/limit=0.
- Asserting rst_b low at any time returns every output to these values immediately.

IDLE:
- When boot_start=1, the next state is RUN with cur_stage=0.
- bypass and limit are captured on that same edge.

RUN:
- stage_req = one-hot(cur_stage) when the current stage is not bypassed, else 0. It is combinational from registered state.
- Handshake: stage_done[cur_stage]=1 while req is high -> next cycle cur_stage+1 and counter cleared. On the last stage it goes to DONE instead.
- Minimum one cycle per stage. A bypassed stage takes exactly 1 cycle with no req.
- stage_done bits of non-current stages are ignored.
- Watchdog (limit != 0): the counter increments each cycle req is high and done is low. When counter==limit-1 and done is low, the next state is ERROR and err_stage<=cur_stage. Effect: req is high for exactly `limit` cycles before ERROR.
- stage_done in the same cycle as timeout: done wins and the stage advances.
- With limit=0 the counter holds 0 and there is never a timeout.

mcu_rst_b:
- 0 until the cycle cur_stage first reaches MCU_STAGE in RUN (bypassed or not), then 1.
- Stays 1 through DONE except in RST_MCU.

DONE:
- boot_done=1.
- mcu_update_req=1 -> RST_MCU next cycle.
- mcu_update_req in any other state is ignored and is not queued.

RST_MCU:
- mcu_rst_b=0 for exactly MCU_RST_CYCLES cycles, counted by an internal down-counter.
- Then DONE, mcu_rst_b=1, update_count+1 (saturating at 255).
- mcu_update_req during RST_MCU is ignored.

ERROR:
- Terminal until rst_b.
- stage_req=0, boot_err=1, mcu_rst_b retains its value.

boot_start:
- Ignored outside IDLE.
- After DONE it never restarts the sequence.

Test Plan:
1. Default params, bypass=0, limit=0, boot_start=1; each stage_done returned 3 cycles after its req. Expect stage_req one-hot 0x01..0x80 in order, each high 4 cycles. mcu_rst_b rises the cycle req=0x10. DONE after 32 cycles, boot_done=1.
2. bypass=0xA5. Expect req only for stages 1,3,4,6. Stages 0,2,5,7 take 1 cycle each with no req. mcu_rst_b rises on entry to stage 4.
3. limit=5, stage 2 never done. Expect req=0x04 high exactly 5 cycles, then boot_state=4, boot_err=1, err_stage=2, stage_req=0. Then stage_done[2]=1 -> no change.
4. limit=5, stage_done[1] asserted exactly on the 5th req cycle. Expect advance to stage 2, no error.
5. In DONE, pulse mcu_update_req, then pulse it again during reset. Expect mcu_rst_b low exactly 10 cycles, back to DONE, update_count=1 (second pulse ignored). A third pulse gives update_count=2.
6. Assert rst_b low mid-RUN at stage 5 and release. Expect all outputs at reset values, state IDLE. A new boot_start restarts at stage 0 using the newly captured bypass/limit.
